pipe_hazard_ctrl: RTL and testbench

//  Pipeline sequencer for the IF/ID register and the PC. It decodes the instruction held in ID and tracks in-flight destinations in EX/MEM/WB with a 3-entry shadow scoreboard.
//  It stalls on RAW hazards, because the design has no forwarding. It flushes on a taken branch and freezes the whole pipe while memory is busy.

---
 rtl/pipe_hazard_ctrl.sv | 146 ++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: sequencer for the PC and the IF/ID register.
// Decodes the instruction in ID and keeps a 3-entry shadow scoreboard of
// destinations in flight (EX, MEM, WB). There is no forwarding, so any RAW
// hazard stalls. A taken branch flushes, and a busy memory freezes the pipe.
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   id_instr     instruction in ID: op[31:27] rd[26:22] ra[21:17] rb[16:12]
//   id_valid     id_instr is a real instruction
//   br_taken     EX resolved a taken branch (pulse)
//   mem_busy     memory stage not ready; freeze everything
//   pc_we        PC may advance
//   ifd_we       IF/ID may capture
//   ifd_flush    IF/ID loads a NOP
//   idex_bubble  ID/EX loads a bubble
//   state_o      0=RUN 1=STALL 2=FLUSH 3=FREEZE (state in effect this cycle)
//   stall_cnt    saturating count of RAW-stall cycles
module pipe_hazard_ctrl #(
  parameter logic [31:0] WRITES_MASK  = 32'hFFFF_00FE,
  parameter logic [31:0] USES_A_MASK  = 32'hFFFF_FFFE,
  parameter logic [31:0] USES_B_MASK  = 32'h0000_FFFE,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] id_instr,
  input  logic        id_valid,
  input  logic        br_taken,
  input  logic        mem_busy,
  output logic        pc_we,
  output logic        ifd_we,
  output logic        ifd_flush,
  output logic        idex_bubble,
  output logic [1:0]  state_o,
  output logic [15:0] stall_cnt
);

  typedef enum logic [1:0] {
    S_RUN    = 2'd0,
    S_STALL  = 2'd1,
    S_FLUSH  = 2'd2,
    S_FREEZE = 2'd3
  } state_t;

  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

  logic [4:0] op, rd, ra, rb;
  logic       wr, ua, ub;
  logic       unused_bits;

  // Scoreboard: index 0 = EX, 1 = MEM, 2 = WB.
  logic [2:0] sb_v;
  logic [4:0] sb_rd [3];
  logic [2:0] flush_cnt;
  logic       br_pend;

  logic   hit_a, hit_b, hazard;
  state_t state;

  assign op          = id_instr[31:27];
  assign rd          = id_instr[26:22];
  assign ra          = id_instr[21:17];
  assign rb          = id_instr[16:12];
  assign unused_bits = ^id_instr[11:0];

  assign wr = WRITES_MASK[op];
  assign ua = USES_A_MASK[op];
  assign ub = USES_B_MASK[op];

  always_comb begin
    hit_a = 1'b0;
    hit_b = 1'b0;
    for (int unsigned i = 0; i < 3; i++) begin
      if (sb_v[i] && sb_rd[i] == ra) hit_a = 1'b1;
      if (sb_v[i] && sb_rd[i] == rb) hit_b = 1'b1;
    end
    hazard = id_valid && ((ua && ra != '0 && hit_a) || (ub && rb != '0 && hit_b));
  end

  // The state is a pure function of registered context and this cycle's
  // inputs, so the outputs settle before the negedge IF/ID capture.
  always_comb begin
    state = S_RUN;
    if (mem_busy)                                  state = S_FREEZE;
    else if (br_taken || br_pend || flush_cnt != '0) state = S_FLUSH;
    else if (hazard)                               state = S_STALL;

    pc_we       = 1'b1;
    ifd_we      = 1'b1;
    ifd_flush   = 1'b0;
    idex_bubble = 1'b0;
    state_o     = state;
    unique case (state)
      S_FREEZE: begin
        pc_we  = 1'b0;
        ifd_we = 1'b0;
      end
      S_FLUSH: begin
        ifd_flush   = 1'b1;
        idex_bubble = 1'b1;
      end
      S_STALL: begin
        pc_we       = 1'b0;
        ifd_we      = 1'b0;
        idex_bubble = 1'b1;
      end
      default: ;
    endcase

    if (rst) begin
      pc_we       = 1'b0;
      ifd_we      = 1'b0;
      ifd_flush   = 1'b1;
      idex_bubble = 1'b1;
      state_o     = S_RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sb_v      <= '0;
      flush_cnt <= '0;
      br_pend   <= 1'b0;
      stall_cnt <= '0;
      for (int unsigned i = 0; i < 3; i++) sb_rd[i] <= '0;
    end else if (state == S_FREEZE) begin
      if (br_taken) br_pend <= 1'b1;
    end else begin
      sb_v[2]  <= sb_v[1];
      sb_rd[2] <= sb_rd[1];
      sb_v[1]  <= sb_v[0];
      sb_rd[1] <= sb_rd[0];
      sb_v[0]  <= (state == S_RUN) && id_valid && wr && (rd != '0);
      sb_rd[0] <= rd;

      if (br_taken || br_pend) begin
        flush_cnt <= FLUSH_LOAD;
        br_pend   <= 1'b0;
      end else if (flush_cnt != '0) begin
        flush_cnt <= flush_cnt - 3'd1;
      end

      if (state == S_STALL && stall_cnt != '1) stall_cnt <= stall_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst, id_valid, br_taken, mem_busy;
  logic [31:0] id_instr;
  logic        pc_we, ifd_we, ifd_flush, idex_bubble;
  logic [1:0]  state_o;
  logic [15:0] stall_cnt;
  logic [5:0]  obs;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_stall = '0;

  // {state_o, pc_we, ifd_we, ifd_flush, idex_bubble}
  localparam logic [5:0] RUN_O    = {2'd0, 4'b1100};
  localparam logic [5:0] STALL_O  = {2'd1, 4'b0001};
  localparam logic [5:0] FLUSH_O  = {2'd2, 4'b1111};
  localparam logic [5:0] FREEZE_O = {2'd3, 4'b0000};
  localparam logic [5:0] RST_O    = {2'd0, 4'b0011};

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.FLUSH_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .id_instr(id_instr), .id_valid(id_valid),
    .br_taken(br_taken), .mem_busy(mem_busy), .pc_we(pc_we), .ifd_we(ifd_we),
    .ifd_flush(ifd_flush), .idex_bubble(idex_bubble), .state_o(state_o),
    .stall_cnt(stall_cnt)
  );

  assign obs = {state_o, pc_we, ifd_we, ifd_flush, idex_bubble};

  function automatic logic [31:0] mk(input logic [4:0] op, input logic [4:0] rd,
                                     input logic [4:0] ra, input logic [4:0] rb);
    return {op, rd, ra, rb, 12'h000};
  endfunction

  task automatic drive(input logic [31:0] ins, input logic v, input logic br,
                       input logic mb, input logic r);
    id_instr = ins; id_valid = v; br_taken = br; mem_busy = mb; rst = r;
  endtask

  task automatic next_cycle;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    drive('0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < n; i++) next_cycle();
  endtask

  task automatic test_reset;
    drive(mk(1, 5, 5, 5), 1'b1, 1'b1, 1'b0, 1'b1);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk); checks++;
      if (obs !== RST_O) begin errors++; $display("FAIL reset_out c%0d: got %b want %b", c, obs, RST_O); end
      next_cycle();
    end
    drive(mk(1, 0, 5, 5), 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk); checks++;
    if (obs !== RUN_O) begin errors++; $display("FAIL reset_run: got %b want %b", obs, RUN_O); end
    checks++;
    if (stall_cnt !== 16'd0) begin errors++; $display("FAIL reset_cnt: got %h want 0000", stall_cnt); end
    next_cycle();
  endtask

  task automatic test_raw;
    logic [31:0] tw [10];
    logic        gp [10];
    logic [31:0] tg [10];
    logic [31:0] td [10];
    logic        dv [10];
    int          ns [10];
    tw = '{mk(1,5,0,0), mk(1,5,0,0), mk(1,0,0,0), mk(1,5,0,0), mk(1,5,0,0),
           mk(16,5,0,0), mk(0,5,0,0), mk(1,5,0,0), mk(8,5,0,0), mk(1,5,0,0)};
    gp = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    tg = '{32'h0, mk(1,7,0,0), 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, mk(1,5,0,0)};
    td = '{mk(1,0,5,0), mk(1,0,5,0), mk(1,0,0,0), mk(1,0,0,5), mk(16,0,0,5),
           mk(16,0,5,0), mk(1,0,5,0), mk(1,0,5,0), mk(1,0,5,0), mk(1,9,5,0)};
    dv = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    ns = '{3, 2, 0, 3, 0, 3, 0, 0, 0, 3};
    for (int k = 0; k < 10; k++) begin
      idle(3);
      drive(tw[k], 1'b1, 1'b0, 1'b0, 1'b0);
      @(negedge clk); checks++;
      if (obs !== RUN_O) begin errors++; $display("FAIL raw%0d_writer: got %b want %b", k, obs, RUN_O); end
      next_cycle();
      if (gp[k]) begin
        drive(tg[k], 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk); checks++;
        if (obs !== RUN_O) begin errors++; $display("FAIL raw%0d_gap: got %b want %b", k, obs, RUN_O); end
        next_cycle();
      end
      drive(td[k], dv[k], 1'b0, 1'b0, 1'b0);
      for (int c = 0; c <= ns[k]; c++) begin
        @(negedge clk); checks++;
        if (obs !== ((c < ns[k]) ? STALL_O : RUN_O)) begin
          errors++;
          $display("FAIL raw%0d_dep c%0d: got %b want %b", k, c, obs, (c < ns[k]) ? STALL_O : RUN_O);
        end
        next_cycle();
      end
      exp_stall = exp_stall + 16'(ns[k]);
      checks++;
      if (stall_cnt !== exp_stall) begin errors++; $display("FAIL raw%0d_cnt: got %0d want %0d", k, stall_cnt, exp_stall); end
    end
  endtask

  task automatic test_branch;
    logic [5:0] e [4];
    logic       b [4];
    idle(3);
    drive(mk(1, 5, 0, 0), 1'b1, 1'b0, 1'b0, 1'b0);
    next_cycle();
    // Taken branch while a hazard is present: flush beats stall.
    drive(mk(1, 0, 5, 0), 1'b1, 1'b1, 1'b0, 1'b0);
    @(negedge clk); checks++;
    if (obs !== FLUSH_O) begin errors++; $display("FAIL br_flush0: got %b want %b", obs, FLUSH_O); end
    next_cycle();
    drive(mk(1, 0, 5, 0), 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk); checks++;
    if (obs !== FLUSH_O) begin errors++; $display("FAIL br_flush1: got %b want %b", obs, FLUSH_O); end
    next_cycle();
    drive('0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk); checks++;
    if (obs !== RUN_O) begin errors++; $display("FAIL br_after: got %b want %b", obs, RUN_O); end
    checks++;
    if (stall_cnt !== exp_stall) begin errors++; $display("FAIL br_cnt: got %0d want %0d", stall_cnt, exp_stall); end
    next_cycle();
    // Second br_taken during FLUSH restarts the counter: three flush cycles.
    e = '{FLUSH_O, FLUSH_O, FLUSH_O, RUN_O};
    b = '{1'b1, 1'b1, 1'b0, 1'b0};
    for (int c = 0; c < 4; c++) begin
      drive('0, 1'b0, b[c], 1'b0, 1'b0);
      @(negedge clk); checks++;
      if (obs !== e[c]) begin errors++; $display("FAIL br_restart c%0d: got %b want %b", c, obs, e[c]); end
      next_cycle();
    end
  endtask

  task automatic test_freeze;
    logic [5:0] e [9];
    idle(3);
    e = '{RUN_O, STALL_O, FREEZE_O, FREEZE_O, FREEZE_O, FREEZE_O, FLUSH_O, FLUSH_O, RUN_O};
    for (int c = 0; c < 9; c++) begin
      if (c == 0)      drive(mk(1, 5, 0, 0), 1'b1, 1'b0, 1'b0, 1'b0);
      else if (c < 8)  drive(mk(1, 0, 5, 0), 1'b1, c == 3, c >= 2 && c <= 5, 1'b0);
      else             drive('0, 1'b0, 1'b0, 1'b0, 1'b0);
      @(negedge clk); checks++;
      if (obs !== e[c]) begin errors++; $display("FAIL frz c%0d: got %b want %b", c, obs, e[c]); end
      next_cycle();
      if (c == 5) begin
        exp_stall = exp_stall + 16'd1;
        checks++;
        if (stall_cnt !== exp_stall) begin errors++; $display("FAIL frz_hold_cnt: got %0d want %0d", stall_cnt, exp_stall); end
      end
    end
    checks++;
    if (stall_cnt !== exp_stall) begin errors++; $display("FAIL frz_cnt: got %0d want %0d", stall_cnt, exp_stall); end
  endtask

  task automatic test_rst_mid_flush;
    idle(3);
    drive(mk(1, 5, 0, 0), 1'b1, 1'b0, 1'b0, 1'b0);
    next_cycle();
    drive('0, 1'b0, 1'b1, 1'b0, 1'b0);
    @(negedge clk); checks++;
    if (obs !== FLUSH_O) begin errors++; $display("FAIL rst_pre: got %b want %b", obs, FLUSH_O); end
    next_cycle();
    drive('0, 1'b0, 1'b0, 1'b0, 1'b1);
    @(negedge clk); checks++;
    if (obs !== RST_O) begin errors++; $display("FAIL rst_mid: got %b want %b", obs, RST_O); end
    next_cycle();
    exp_stall = '0;
    drive(mk(1, 0, 5, 0), 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk); checks++;
    if (obs !== RUN_O) begin errors++; $display("FAIL rst_dep: got %b want %b", obs, RUN_O); end
    checks++;
    if (stall_cnt !== 16'd0) begin errors++; $display("FAIL rst_cnt: got %0d want 0", stall_cnt); end
    next_cycle();
  endtask

  task automatic test_saturate;
    int mism = 0;
    int raw  = 0;
    logic stall;
    idle(3);
    // Self-dependent writer: RUN, then 3 STALLs, repeating.
    drive(mk(1, 5, 5, 0), 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 87387; i++) begin
      stall = (i % 4) != 0;
      @(negedge clk);
      if (obs !== (stall ? STALL_O : RUN_O)) begin
        mism++;
        if (mism <= 3) $display("FAIL sat_pattern i%0d: got %b want %b", i, obs, stall ? STALL_O : RUN_O);
      end
      next_cycle();
      if (stall) begin
        raw++;
        if (exp_stall != 16'hFFFF) exp_stall = exp_stall + 16'd1;
        if (raw == 65534 || raw == 65535) begin
          checks++;
          if (stall_cnt !== exp_stall) begin errors++; $display("FAIL sat_cnt_%0d: got %h want %h", raw, stall_cnt, exp_stall); end
        end
      end
    end
    checks++;
    if (mism != 0) begin errors++; $display("FAIL sat_pattern_total: got %0d mismatching cycles want 0", mism); end
    checks++;
    if (stall_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_final: got %h want ffff", stall_cnt); end
  endtask

  initial begin
    drive('0, 1'b0, 1'b0, 1'b0, 1'b1);
    @(posedge clk); #1;
    test_reset();
    test_raw();
    test_branch();
    test_freeze();
    test_rst_mid_flush();
    test_saturate();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
